// File: rtl/ml_pkg.sv
// Shared dual-rail token encoding, channel state codes and combine helpers
// for the clocked yellow-cell handshake bank.
package ml_pkg;

    localparam logic [1:0] VEMPTY   = 2'b00;
    localparam logic [1:0] V0       = 2'b01;
    localparam logic [1:0] V1       = 2'b10;
    localparam logic [1:0] VILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } chan_state_e;

    // Plain-vector aliases so state registers stay legacy-compatible logic.
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_HALF  = ST_HALF;
    localparam logic [1:0] S_FULL  = ST_FULL;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;

    function automatic logic is_valid(input logic [1:0] v);
        return (v == V0) || (v == V1);
    endfunction

    // mode 0: AND (V1 only when both are V1); mode 1: EQ (V1 when a == b).
    function automatic logic [1:0] combine(input logic mode, input logic [1:0] a,
                                           input logic [1:0] b);
        if (mode)
            return (a == b) ? V1 : V0;
        else
            return ((a == V1) && (b == V1)) ? V1 : V0;
    endfunction

endpackage

// File: rtl/ycfsm_bank_chan.sv
// One return-to-empty channel: FSM, first-valid-wins latches, registered
// dual-rail result, watchdog counter and sticky err/stuck flags.
module ycfsm_chan
    import ml_pkg::*;
#(
    parameter int MODE    = 0,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_in,
    input  logic [1:0] i_match,
    input  logic       i_err_clr,
    output logic [1:0] o_out,
    output logic       o_busy,
    output logic       o_err,
    output logic       o_stuck
);

    localparam int             CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);
    localparam logic           W_MODE  = (MODE != 0);

    logic [1:0]    r_state;
    logic [1:0]    r_in_prev;
    logic [1:0]    r_m_prev;
    logic [1:0]    r_lat_in;
    logic [1:0]    r_lat_m;
    logic [1:0]    r_out;
    logic          r_err;
    logic          r_stuck;
    logic [CW-1:0] r_cnt;

    logic [1:0]    w_in;
    logic [1:0]    w_m;
    logic          w_in_v;
    logic          w_m_v;
    logic          w_new_err;
    logic [1:0]    w_state_nx;
    logic [1:0]    w_lat_in_nx;
    logic [1:0]    w_lat_m_nx;
    logic [1:0]    w_out_nx;
    logic          w_stall;
    logic [CW-1:0] w_cnt_nx;
    logic          w_hit;

    // Handshake: a token is offered by driving V0/V1 and withdrawn by returning
    // to VEMPTY; an illegal code reuses last cycle's decoded value.
    always_comb begin
        w_in   = (i_in == VILLEGAL) ? r_in_prev : i_in;
        w_m    = (i_match == VILLEGAL) ? r_m_prev : i_match;
        w_in_v = is_valid(w_in);
        w_m_v  = is_valid(w_m);
        w_new_err = (i_in == VILLEGAL) || (i_match == VILLEGAL)
                  || (w_in_v && is_valid(r_in_prev) && (w_in != r_in_prev))
                  || (w_m_v && is_valid(r_m_prev) && (w_m != r_m_prev));
    end

    always_comb begin
        w_state_nx  = r_state;
        w_lat_in_nx = r_lat_in;
        w_lat_m_nx  = r_lat_m;
        case (r_state)
            S_IDLE: begin
                if (w_in_v) w_lat_in_nx = w_in;
                if (w_m_v)  w_lat_m_nx  = w_m;
                if (w_in_v && w_m_v)     w_state_nx = S_FULL;
                else if (w_in_v || w_m_v) w_state_nx = S_HALF;
            end
            S_HALF: begin
                // Withdrawal of the held token wins over arrival of the other.
                if (is_valid(r_lat_in) ? !w_in_v : !w_m_v) begin
                    w_state_nx  = S_IDLE;
                    w_lat_in_nx = VEMPTY;
                    w_lat_m_nx  = VEMPTY;
                end else if (is_valid(r_lat_in) ? w_m_v : w_in_v) begin
                    w_state_nx = S_FULL;
                    if (is_valid(r_lat_in)) w_lat_m_nx  = w_m;
                    else                    w_lat_in_nx = w_in;
                end
            end
            S_FULL: begin
                if (!w_in_v && !w_m_v) begin
                    w_state_nx  = S_IDLE;
                    w_lat_in_nx = VEMPTY;
                    w_lat_m_nx  = VEMPTY;
                end else if (!w_in_v || !w_m_v) begin
                    w_state_nx = S_DRAIN;
                end
            end
            default: begin
                if (!w_in_v && !w_m_v) begin
                    w_state_nx  = S_IDLE;
                    w_lat_in_nx = VEMPTY;
                    w_lat_m_nx  = VEMPTY;
                end
            end
        endcase
    end

    always_comb begin
        w_out_nx = r_out;
        if (w_state_nx == S_FULL && r_state != S_FULL)
            w_out_nx = combine(W_MODE, w_lat_in_nx, w_lat_m_nx);
        else if (w_state_nx == S_IDLE || w_state_nx == S_HALF)
            w_out_nx = VEMPTY;
    end

    always_comb begin
        w_stall  = ((r_state == S_HALF) || (r_state == S_DRAIN)) && (w_state_nx == r_state);
        w_cnt_nx = '0;
        if (w_stall && (TIMEOUT > 0))
            w_cnt_nx = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
        w_hit = w_stall && (TIMEOUT > 0) && (w_cnt_nx == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_in_prev <= VEMPTY;
            r_m_prev  <= VEMPTY;
            r_lat_in  <= VEMPTY;
            r_lat_m   <= VEMPTY;
            r_out     <= VEMPTY;
            r_err     <= 1'b0;
            r_stuck   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_in_prev <= w_in;
            r_m_prev  <= w_m;
            r_lat_in  <= w_lat_in_nx;
            r_lat_m   <= w_lat_m_nx;
            r_out     <= w_out_nx;
            r_err     <= (r_err & ~i_err_clr) | w_new_err;
            r_stuck   <= (r_stuck & ~i_err_clr) | w_hit;
            r_cnt     <= w_cnt_nx;
        end
    end

    assign o_out   = r_out;
    assign o_busy  = (r_state != S_IDLE);
    assign o_err   = r_err;
    assign o_stuck = r_stuck;

endmodule

// File: rtl/ycfsm_bank.sv
// Bank of N independent dual-rail handshake channels; only port slicing here.
module ycfsm_bank #(
    parameter int N       = 4,
    parameter int MODE    = 0,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2*N-1:0] i_in,
    input  logic [2*N-1:0] i_match,
    input  logic           i_err_clr,
    output logic [2*N-1:0] o_out,
    output logic [N-1:0]   o_busy,
    output logic [N-1:0]   o_err,
    output logic [N-1:0]   o_stuck
);

    for (genvar k = 0; k < N; k++) begin : g_chan
        ycfsm_chan #(
            .MODE    (MODE),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .i_in      (i_in[2*k+1:2*k]),
            .i_match   (i_match[2*k+1:2*k]),
            .i_err_clr (i_err_clr),
            .o_out     (o_out[2*k+1:2*k]),
            .o_busy    (o_busy[k]),
            .o_err     (o_err[k]),
            .o_stuck   (o_stuck[k])
        );
    end

endmodule

// File: tb/tb_ycfsm_bank.sv
// Bench for ycfsm_bank: an AND-mode and an EQ-mode bank (TIMEOUT=5) share
// stimulus; expected outputs are queued per cycle and compared after the edge.
module tb_ycfsm_bank;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] r_in = '0;
  logic [7:0] r_match = '0;
  logic r_clr = 1'b0;

  logic [7:0] a_out, b_out;
  logic [3:0] a_busy, a_err, a_stuck, b_busy, b_err, b_stuck;

  logic [39:0] exp_q[$];
  logic [39:0] obs, expv;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ycfsm_bank #(.N(4), .MODE(0), .TIMEOUT(5)) u_dut_and (
    .clk(clk), .reset(reset), .i_in(r_in), .i_match(r_match), .i_err_clr(r_clr),
    .o_out(a_out), .o_busy(a_busy), .o_err(a_err), .o_stuck(a_stuck)
  );

  ycfsm_bank #(.N(4), .MODE(1), .TIMEOUT(5)) u_dut_eq (
    .clk(clk), .reset(reset), .i_in(r_in), .i_match(r_match), .i_err_clr(r_clr),
    .o_out(b_out), .o_busy(b_busy), .o_err(b_err), .o_stuck(b_stuck)
  );

  function automatic logic [39:0] mk(logic [7:0] ao, logic [7:0] bo, logic [3:0] busy,
                                     logic [3:0] err, logic [3:0] stuck);
    return {ao, busy, err, stuck, bo, busy, err, stuck};
  endfunction

  function automatic logic [39:0] snap();
    return {a_out, a_busy, a_err, a_stuck, b_out, b_busy, b_err, b_stuck};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; r_in = 8'hFF; r_match = 8'hFF; r_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin r_in = '0; r_match = '0; r_clr = 1'b0; end
      exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'h0, 4'h0));
      tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_%0d got %h expected %h", i, obs, expv); end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    r_in = 8'h02;
    exp_q.push_back(mk(8'h00, 8'h00, 4'b0001, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL basic_half got %h expected %h", obs, expv); end
    exp_q.push_back(mk(8'h00, 8'h00, 4'b0001, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL basic_wait got %h expected %h", obs, expv); end
    r_match = 8'h02;
    exp_q.push_back(mk(8'h02, 8'h02, 4'b0001, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL basic_full got %h expected %h", obs, expv); end
    r_match = 8'h00;
    exp_q.push_back(mk(8'h02, 8'h02, 4'b0001, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL basic_drain got %h expected %h", obs, expv); end
    r_in = 8'h00;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL basic_idle got %h expected %h", obs, expv); end
  endtask

  task automatic test_mode();
    r_in = 8'h04; r_match = 8'h04;
    exp_q.push_back(mk(8'h04, 8'h08, 4'b0010, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL mode_v0v0 got %h expected %h", obs, expv); end
    r_in = 8'h00; r_match = 8'h00;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL mode_empty1 got %h expected %h", obs, expv); end
    r_in = 8'h04; r_match = 8'h08;
    exp_q.push_back(mk(8'h04, 8'h04, 4'b0010, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL mode_v0v1 got %h expected %h", obs, expv); end
    r_in = 8'h00; r_match = 8'h00;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL mode_empty2 got %h expected %h", obs, expv); end
  endtask

  task automatic test_protocol();
    r_in = 8'h20;
    exp_q.push_back(mk(8'h00, 8'h00, 4'b0100, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL proto_half got %h expected %h", obs, expv); end
    r_in = 8'h10;
    exp_q.push_back(mk(8'h00, 8'h00, 4'b0100, 4'b0100, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL proto_flip got %h expected %h", obs, expv); end
    r_match = 8'h20;
    exp_q.push_back(mk(8'h20, 8'h20, 4'b0100, 4'b0100, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL proto_latched got %h expected %h", obs, expv); end
    r_clr = 1'b1;
    exp_q.push_back(mk(8'h20, 8'h20, 4'b0100, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL proto_clr got %h expected %h", obs, expv); end
    r_clr = 1'b0; r_in = 8'h00; r_match = 8'h00;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL proto_idle got %h expected %h", obs, expv); end
  endtask

  task automatic test_illegal();
    r_match = 8'hC0;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'b1000, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL illegal_set got %h expected %h", obs, expv); end
    r_match = 8'h00;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'b1000, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL illegal_sticky got %h expected %h", obs, expv); end
    r_match = 8'hC0; r_clr = 1'b1;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'b1000, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL illegal_clr_race got %h expected %h", obs, expv); end
    r_match = 8'h00;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL illegal_clr got %h expected %h", obs, expv); end
    r_clr = 1'b0;
  endtask

  task automatic test_watchdog();
    r_in = 8'h02;
    exp_q.push_back(mk(8'h00, 8'h00, 4'b0001, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL wdog_enter got %h expected %h", obs, expv); end
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(mk(8'h00, 8'h00, 4'b0001, 4'h0, (i == 5) ? 4'b0001 : 4'b0000));
      tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL wdog_cycle%0d got %h expected %h", i, obs, expv); end
    end
    r_match = 8'h02;
    exp_q.push_back(mk(8'h02, 8'h02, 4'b0001, 4'h0, 4'b0001));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL wdog_full got %h expected %h", obs, expv); end
    r_in = 8'h00; r_match = 8'h00;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'h0, 4'b0001));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL wdog_hold got %h expected %h", obs, expv); end
    r_clr = 1'b1;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL wdog_clr got %h expected %h", obs, expv); end
    r_clr = 1'b0;
  endtask

  task automatic test_independent();
    r_in = 8'h66; r_match = 8'h5A;
    exp_q.push_back(mk(8'h56, 8'h96, 4'hF, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL indep_full got %h expected %h", obs, expv); end
    r_in = 8'h00; r_match = 8'h00;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL indep_idle got %h expected %h", obs, expv); end
  endtask

  task automatic test_reset_mid();
    r_in = 8'h02; r_match = 8'h02;
    exp_q.push_back(mk(8'h02, 8'h02, 4'b0001, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL rmid_full got %h expected %h", obs, expv); end
    reset = 1'b1;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL rmid_reset got %h expected %h", obs, expv); end
    reset = 1'b0;
    exp_q.push_back(mk(8'h02, 8'h02, 4'b0001, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL rmid_refill got %h expected %h", obs, expv); end
    r_in = 8'h00; r_match = 8'h00;
    exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'h0, 4'h0));
    tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL rmid_idle got %h expected %h", obs, expv); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] vi, vm, ea, eb;
    int k;
    for (int it = 0; it < 6; it++) begin
      vi = 2'($urandom_range(1, 2));
      vm = 2'($urandom_range(1, 2));
      k  = $urandom_range(0, 2);
      ea = ((vi == 2'b10) && (vm == 2'b10)) ? 2'b10 : 2'b01;
      eb = (vi == vm) ? 2'b10 : 2'b01;
      r_in = {4'b0, vi, 2'b0};
      for (int j = 0; j <= k; j++) begin
        exp_q.push_back(mk(8'h00, 8'h00, 4'b0010, 4'h0, 4'h0));
        tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
        if (obs !== expv) begin errors++; $display("FAIL b2b_half%0d got %h expected %h", it, obs, expv); end
      end
      r_match = {4'b0, vm, 2'b0};
      exp_q.push_back(mk({4'b0, ea, 2'b0}, {4'b0, eb, 2'b0}, 4'b0010, 4'h0, 4'h0));
      tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL b2b_full%0d got %h expected %h", it, obs, expv); end
      r_in = 8'h00; r_match = 8'h00;
      exp_q.push_back(mk(8'h00, 8'h00, 4'h0, 4'h0, 4'h0));
      tick(); obs = snap(); expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL b2b_idle%0d got %h expected %h", it, obs, expv); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mode();
    test_protocol();
    test_illegal();
    test_watchdog();
    test_independent();
    test_reset_mid();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
